// File: rtl/pipeline_stall_sequencer.sv
// pipeline_stall_sequencer
// Multi-cycle stall/flush sequencer for the 5-stage pipeline. It detects
// load-use and control hazards in Decode. It holds the matching stall/flush
// pattern for a programmable number of cycles. It freezes F/D/E while the data
// memory is busy. It also keeps a saturating stall-cycle counter and a sticky
// memory-timeout error flag.
module pipeline_stall_sequencer #(
   parameter int BR_PENALTY  = 2,   // total stall cycles per control hazard (>=1)
   parameter int LD_PENALTY  = 1,   // total stall cycles per load-use hazard (>=1)
   parameter int MEM_TIMEOUT = 15,  // busy cycles before MemErr is raised (>=1)
   parameter int CNT_W       = 16   // StallCount width
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             BranchD,
   input  logic             ForSignalD,
   input  logic             MemReadE,
   input  logic [2:0]       RdE,
   input  logic [2:0]       RsD,
   input  logic [2:0]       RtD,
   input  logic             UseRtD,
   input  logic             MemBusyM,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             FlushD,
   output logic             FlushE,
   output logic             Busy,
   output logic             MemErr,
   output logic [CNT_W-1:0] StallCount
);

   localparam int MAX_PEN = (BR_PENALTY > LD_PENALTY) ? BR_PENALTY : LD_PENALTY;
   // The wait counter only has to hold MAX_PEN-2.
   localparam int CW = (MAX_PEN > 2) ? $clog2(MAX_PEN - 1) : 1;
   localparam int TW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0] LD_INIT = CW'((LD_PENALTY > 1) ? LD_PENALTY - 2 : 0);
   localparam logic [CW-1:0] BR_INIT = CW'((BR_PENALTY > 1) ? BR_PENALTY - 2 : 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LD_WAIT,
      S_CTL_WAIT,
      S_MEM_WAIT
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [CW-1:0]    r_cnt, w_cnt_nxt;
   logic [TW-1:0]    r_mem_timer;
   logic             r_mem_err;
   logic [CNT_W-1:0] r_stall_cnt;

   logic w_lu, w_ctl;
   logic w_sf, w_sd, w_se, w_fd, w_fe;

   assign w_lu  = MemReadE & (RdE != 3'd0) &
                  ((RdE == RsD) | (UseRtD & (RdE == RtD)));
   assign w_ctl = BranchD | ForSignalD;

   // State register and wait counter.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state, counter update and Mealy stall/flush outputs.
   // NOTE: every signal assigned here gets a default first, otherwise a latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_sf        = 1'b0;
      w_sd        = 1'b0;
      w_se        = 1'b0;
      w_fd        = 1'b0;
      w_fe        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (MemBusyM) begin
               w_sf        = 1'b1;
               w_sd        = 1'b1;
               w_se        = 1'b1;
               w_state_nxt = S_MEM_WAIT;
            end else if (w_lu) begin
               w_sf = 1'b1;
               w_sd = 1'b1;
               w_fe = 1'b1;
               if (LD_PENALTY > 1) begin
                  w_state_nxt = S_LD_WAIT;
                  w_cnt_nxt   = LD_INIT;
               end
            end else if (w_ctl) begin
               // The branch itself moves on to Execute; only the wrong-path fetch is squashed.
               w_sf = 1'b1;
               w_fd = 1'b1;
               if (BR_PENALTY > 1) begin
                  w_state_nxt = S_CTL_WAIT;
                  w_cnt_nxt   = BR_INIT;
               end
            end
         end
         S_LD_WAIT, S_CTL_WAIT: begin
            if (MemBusyM) begin
               // Memory freeze overrides the pattern; the counter holds its value.
               w_sf = 1'b1;
               w_sd = 1'b1;
               w_se = 1'b1;
            end else begin
               w_sf = 1'b1;
               if (r_state == S_LD_WAIT) begin
                  w_sd = 1'b1;
                  w_fe = 1'b1;
               end else begin
                  w_fd = 1'b1;
               end
               if (r_cnt == '0) begin
                  w_state_nxt = S_IDLE;
               end else begin
                  w_cnt_nxt = r_cnt - 1'b1;
               end
            end
         end
         S_MEM_WAIT: begin
            if (MemBusyM) begin
               w_sf = 1'b1;
               w_sd = 1'b1;
               w_se = 1'b1;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Memory-busy timer and sticky timeout flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem_timer <= '0;
         r_mem_err   <= 1'b0;
      end else if (MemBusyM) begin
         if (r_mem_timer != TW'(MEM_TIMEOUT)) begin
            r_mem_timer <= r_mem_timer + 1'b1;
         end
         if (r_mem_timer == TW'(MEM_TIMEOUT - 1)) begin
            r_mem_err <= 1'b1;
         end
      end else begin
         r_mem_timer <= '0;
      end
   end

   // Saturating count of cycles with StallF asserted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
      end else if (w_sf && (r_stall_cnt != {CNT_W{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   // Outputs are forced low while reset is held, even though they are Mealy terms.
   assign StallF     = w_sf & rst_n;
   assign StallD     = w_sd & rst_n;
   assign StallE     = w_se & rst_n;
   assign FlushD     = w_fd & rst_n;
   assign FlushE     = w_fe & rst_n;
   assign Busy       = (r_state != S_IDLE);
   assign MemErr     = r_mem_err;
   assign StallCount = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// Testbench for pipeline_stall_sequencer.
// Instance A: BR_PENALTY=3, LD_PENALTY=1, MEM_TIMEOUT=15, CNT_W=16.
// Instance B: BR_PENALTY=2, LD_PENALTY=2, MEM_TIMEOUT=4,  CNT_W=4.
// Cycle vectors are applied through a scoreboard queue.
// Each vector pairs its inputs with the expected {StallF,StallD,StallE,FlushD,FlushE,Busy}.
module tb_pipeline_stall_sequencer;

   // Expected output bundles {sf,sd,se,fd,fe,busy}
   localparam logic [5:0] O_NONE = 6'b000000;
   localparam logic [5:0] O_LU   = 6'b110010;
   localparam logic [5:0] O_CTL  = 6'b100100;
   localparam logic [5:0] O_MEM  = 6'b111000;
   localparam logic [5:0] BSY    = 6'b000001;

   typedef struct {
      logic       sel;    // 0 = instance A, 1 = instance B
      logic       br, fs, mr;
      logic [2:0] rde, rsd, rtd;
      logic       ut, mb;
      logic [5:0] exp_o;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic       a_br = 0, a_fs = 0, a_mr = 0, a_ut = 0, a_mb = 0;
   logic [2:0] a_rde = 0, a_rsd = 0, a_rtd = 0;
   logic       a_sf, a_sd, a_se, a_fd, a_fe, a_busy, a_err;
   logic [15:0] a_cnt;

   logic       b_br = 0, b_fs = 0, b_mr = 0, b_ut = 0, b_mb = 0;
   logic [2:0] b_rde = 0, b_rsd = 0, b_rtd = 0;
   logic       b_sf, b_sd, b_se, b_fd, b_fe, b_busy, b_err;
   logic [3:0] b_cnt;

   int n_vec  = 0;
   int n_miss = 0;
   int model_cnt_a = 0;
   int model_cnt_b = 0;
   vec_t sb_q[$];
   vec_t tbl[$];

   always #5 clk = ~clk;

   pipeline_stall_sequencer #(
      .BR_PENALTY(3), .LD_PENALTY(1), .MEM_TIMEOUT(15), .CNT_W(16)
   ) u_dut_a (
      .clk(clk), .rst_n(rst_n),
      .BranchD(a_br), .ForSignalD(a_fs), .MemReadE(a_mr),
      .RdE(a_rde), .RsD(a_rsd), .RtD(a_rtd), .UseRtD(a_ut), .MemBusyM(a_mb),
      .StallF(a_sf), .StallD(a_sd), .StallE(a_se), .FlushD(a_fd), .FlushE(a_fe),
      .Busy(a_busy), .MemErr(a_err), .StallCount(a_cnt)
   );

   pipeline_stall_sequencer #(
      .BR_PENALTY(2), .LD_PENALTY(2), .MEM_TIMEOUT(4), .CNT_W(4)
   ) u_dut_b (
      .clk(clk), .rst_n(rst_n),
      .BranchD(b_br), .ForSignalD(b_fs), .MemReadE(b_mr),
      .RdE(b_rde), .RsD(b_rsd), .RtD(b_rtd), .UseRtD(b_ut), .MemBusyM(b_mb),
      .StallF(b_sf), .StallD(b_sd), .StallE(b_se), .FlushD(b_fd), .FlushE(b_fe),
      .Busy(b_busy), .MemErr(b_err), .StallCount(b_cnt)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   function automatic vec_t mk(input logic sel, input logic br, input logic fs, input logic mr,
                               input logic [2:0] rde, input logic [2:0] rsd, input logic [2:0] rtd,
                               input logic ut, input logic mb, input logic [5:0] exp_o);
      vec_t v;
      v.sel = sel; v.br = br; v.fs = fs; v.mr = mr;
      v.rde = rde; v.rsd = rsd; v.rtd = rtd; v.ut = ut; v.mb = mb;
      v.exp_o = exp_o;
      return v;
   endfunction

   // One cycle: drive after the rising edge, score on the falling edge.
   task automatic apply(input vec_t v, input string name);
      vec_t e;
      logic [5:0] got;
      @(posedge clk);
      #1;
      a_br = 0; a_fs = 0; a_mr = 0; a_rde = 0; a_rsd = 0; a_rtd = 0; a_ut = 0; a_mb = 0;
      b_br = 0; b_fs = 0; b_mr = 0; b_rde = 0; b_rsd = 0; b_rtd = 0; b_ut = 0; b_mb = 0;
      if (!v.sel) begin
         a_br = v.br; a_fs = v.fs; a_mr = v.mr; a_rde = v.rde; a_rsd = v.rsd;
         a_rtd = v.rtd; a_ut = v.ut; a_mb = v.mb;
         if (v.exp_o[5] && model_cnt_a < 65535) model_cnt_a++;
      end else begin
         b_br = v.br; b_fs = v.fs; b_mr = v.mr; b_rde = v.rde; b_rsd = v.rsd;
         b_rtd = v.rtd; b_ut = v.ut; b_mb = v.mb;
         if (v.exp_o[5] && model_cnt_b < 15) model_cnt_b++;
      end
      sb_q.push_back(v);
      @(negedge clk);
      e = sb_q.pop_front();
      got = e.sel ? {b_sf, b_sd, b_se, b_fd, b_fe, b_busy}
                  : {a_sf, a_sd, a_se, a_fd, a_fe, a_busy};
      check(name, 32'(got), 32'(e.exp_o));
   endtask

   // Holds MemBusyM on the chosen instance for n cycles, then releases it for one cycle.
   task automatic mem_burst(input logic sel, input int n, input string name);
      for (int i = 0; i < n; i++)
         apply(mk(sel,0,0,0,0,0,0,0,1, (i == 0) ? O_MEM : (O_MEM | BSY)), name);
      apply(mk(sel,0,0,0,0,0,0,0,0, O_NONE | BSY), {name, "_release"});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state: outputs held low even with MemBusyM asserted.
      a_mb = 1;
      #12;
      check("reset_outputs", 32'({a_sf, a_sd, a_se, a_fd, a_fe, a_busy}), 32'(O_NONE));
      check("reset_err_cnt", 32'({a_err, a_cnt}), 32'd0);
      a_mb = 0;
      @(negedge clk);
      rst_n = 1;

      // Instance A cycle table (BR_PENALTY=3, LD_PENALTY=1)
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0, O_NONE));        // idle
      tbl.push_back(mk(0,0,0,1,3,3,0,0,0, O_LU));          // load-use on Rs, single cycle
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0, O_NONE));
      tbl.push_back(mk(0,0,0,1,0,0,0,0,0, O_NONE));        // r0 exempt
      tbl.push_back(mk(0,0,0,1,2,1,2,0,0, O_NONE));        // Rt match but UseRtD=0
      tbl.push_back(mk(0,0,0,1,2,1,2,1,0, O_LU));          // Rt match with UseRtD=1
      tbl.push_back(mk(0,0,0,0,2,2,0,0,0, O_NONE));        // not a load
      tbl.push_back(mk(0,1,0,0,0,0,0,0,0, O_CTL));         // branch, 3 cycles
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0, O_CTL | BSY));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0, O_CTL | BSY));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0, O_NONE));
      tbl.push_back(mk(0,0,1,0,0,0,0,0,0, O_CTL));         // for-loop control
      tbl.push_back(mk(0,0,1,1,3,3,0,0,0, O_CTL | BSY));   // hazards ignored while waiting
      tbl.push_back(mk(0,1,0,0,0,0,0,0,0, O_CTL | BSY));
      tbl.push_back(mk(0,1,0,1,3,3,0,0,0, O_LU));          // lu beats ctl
      tbl.push_back(mk(0,1,0,1,3,3,0,0,1, O_MEM));         // MemBusyM beats lu
      tbl.push_back(mk(0,0,0,0,0,0,0,0,1, O_MEM | BSY));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0, O_NONE | BSY));  // release cycle: all low
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0, O_NONE));
      tbl.push_back(mk(0,1,0,0,0,0,0,0,0, O_CTL));         // busy in 2nd wait cycle
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0, O_CTL | BSY));
      for (int i = 0; i < 4; i++)
         tbl.push_back(mk(0,0,0,0,0,0,0,0,1, O_MEM | BSY));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0, O_CTL | BSY));   // remaining ctl cycle
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0, O_NONE));
      tbl.push_back(mk(0,1,0,0,0,0,0,0,0, O_CTL));         // busy in 1st wait cycle: cnt frozen
      tbl.push_back(mk(0,0,0,0,0,0,0,0,1, O_MEM | BSY));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0, O_CTL | BSY));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0, O_CTL | BSY));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0, O_NONE));
      for (int i = 0; i < tbl.size(); i++)
         apply(tbl[i], $sformatf("vecA_%0d", i));
      check("a_stallcount_table", 32'(a_cnt), 32'(model_cnt_a));
      check("a_memerr_short", 32'(a_err), 32'd0);

      // Memory timeout on A: 14 busy cycles stay quiet, 15 set the sticky flag.
      mem_burst(0, 14, "a_busy14");
      check("a_memerr_14", 32'(a_err), 32'd0);
      mem_burst(0, 15, "a_busy15");
      check("a_memerr_15", 32'(a_err), 32'd1);
      apply(mk(0,0,0,0,0,0,0,0,0, O_NONE), "a_after_err");
      check("a_memerr_sticky", 32'(a_err), 32'd1);
      check("a_stallcount_mem", 32'(a_cnt), 32'(model_cnt_a));

      // Instance B: LD_PENALTY=2 and BR_PENALTY=2 multi-cycle paths.
      apply(mk(1,0,0,1,5,5,0,0,0, O_LU), "b_lu0");
      apply(mk(1,0,0,0,0,0,0,0,0, O_LU | BSY), "b_lu1");
      apply(mk(1,0,0,0,0,0,0,0,0, O_NONE), "b_lu_done");
      apply(mk(1,1,0,0,0,0,0,0,0, O_CTL), "b_br0");
      apply(mk(1,0,0,0,0,0,0,0,0, O_CTL | BSY), "b_br1");
      apply(mk(1,0,0,0,0,0,0,0,0, O_NONE), "b_br_done");
      apply(mk(1,0,0,1,5,0,5,1,0, O_LU), "b_lu_rt");
      apply(mk(1,0,0,0,0,0,0,0,1, O_MEM | BSY), "b_ldwait_mem");
      apply(mk(1,0,0,0,0,0,0,0,0, O_LU | BSY), "b_ldwait_resume");
      apply(mk(1,0,0,0,0,0,0,0,0, O_NONE), "b_ld_done");
      check("b_stallcount_pre", 32'(b_cnt), 32'(model_cnt_b));
      mem_burst(1, 12, "b_sat");
      check("b_stallcount_sat", 32'(b_cnt), 32'd15);
      check("b_memerr", 32'(b_err), 32'd1);
      mem_burst(1, 3, "b_sat_more");
      check("b_stallcount_hold", 32'(b_cnt), 32'(model_cnt_b));

      // Reset pulse mid-CTL_WAIT on A, with MemBusyM raised at the same time.
      apply(mk(0,1,0,0,0,0,0,0,0, O_CTL), "a_pre_reset_br");
      @(posedge clk);
      #1;
      a_br = 0; a_mb = 1;
      #2;
      rst_n = 0;
      #1;
      check("async_reset_outputs", 32'({a_sf, a_sd, a_se, a_fd, a_fe, a_busy}), 32'(O_NONE));
      check("async_reset_err_cnt", 32'({a_err, a_cnt}), 32'd0);
      check("async_reset_b_cnt", 32'({b_err, b_cnt}), 32'd0);
      model_cnt_a = 0;
      model_cnt_b = 0;
      a_mb = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
      apply(mk(0,0,0,0,0,0,0,0,0, O_NONE), "a_post_reset_idle");
      apply(mk(0,1,0,0,0,0,0,0,0, O_CTL), "a_post_reset_br0");
      apply(mk(0,0,0,0,0,0,0,0,0, O_CTL | BSY), "a_post_reset_br1");
      apply(mk(0,0,0,0,0,0,0,0,0, O_CTL | BSY), "a_post_reset_br2");
      apply(mk(0,0,0,0,0,0,0,0,0, O_NONE), "a_post_reset_done");
      check("a_stallcount_post_reset", 32'(a_cnt), 32'(model_cnt_a));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
